// File: rtl/gate_pkg.sv
// ============================================================================
// Module      : gate_pkg
// Description : Shared servo PWM timing constants and decoder enumerations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gate_pkg;

    // Nominal timing in 50 MHz cycles, shared with the servo PWM generator.
    localparam int C_OPEN_WIDTH  = 80_000;
    localparam int C_CLOSE_WIDTH = 26_000;
    localparam int C_PERIOD      = 1_500_001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } dec_state_t;

    typedef enum logic [1:0] {
        CLS_NONE  = 2'd0,
        CLS_OPEN  = 2'd1,
        CLS_CLOSE = 2'd2
    } pulse_cls_t;

endpackage

`default_nettype wire

// File: rtl/pwm_edge_sync.sv
// ============================================================================
// Module      : pwm_edge_sync
// Description : Two-flop synchroniser with registered rise/fall strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_delay;
    logic [2:0] r_valid;

    // Strobes stay masked until the delay stage holds a real sample, so a line
    // already high at reset release is not mistaken for a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_delay <= 1'b0;
            r_valid <= 3'b000;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            r_delay <= r_sync2;
            r_valid <= {r_valid[1:0], 1'b1};
            rise    <= r_valid[2] &  r_sync2 & ~r_delay;
            fall    <= r_valid[2] & ~r_sync2 &  r_delay;
        end
    end

endmodule

`default_nettype wire

// File: rtl/servo_pwm_decoder.sv
// ============================================================================
// Module      : servo_pwm_decoder
// Description : Measures servo PWM pulses and decodes debounced gate state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module servo_pwm_decoder
    import gate_pkg::*;
#(
    parameter int CNT_W       = 22,
    parameter int OPEN_WIDTH  = C_OPEN_WIDTH,
    parameter int CLOSE_WIDTH = C_CLOSE_WIDTH,
    parameter int WIDTH_TOL   = 2_000,
    parameter int PERIOD      = C_PERIOD,
    parameter int PERIOD_TOL  = 15_000,
    parameter int TIMEOUT_CYC = 3_000_000,
    parameter int CONFIRM     = 2
) (
    input  logic             clock_50MHz,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] pulse_width,
    output logic             width_valid,
    output logic             gate_open,
    output logic             gate_closed,
    output logic             pwm_error,
    output logic             signal_lost
);

    localparam int CONF_W = $clog2(CONFIRM + 1);
    localparam logic [CNT_W-1:0] OPEN_LO    = CNT_W'(OPEN_WIDTH - WIDTH_TOL);
    localparam logic [CNT_W-1:0] OPEN_HI    = CNT_W'(OPEN_WIDTH + WIDTH_TOL);
    localparam logic [CNT_W-1:0] CLOSE_LO   = CNT_W'(CLOSE_WIDTH - WIDTH_TOL);
    localparam logic [CNT_W-1:0] CLOSE_HI   = CNT_W'(CLOSE_WIDTH + WIDTH_TOL);
    localparam logic [CNT_W-1:0] PER_LO     = CNT_W'(PERIOD - PERIOD_TOL);
    localparam logic [CNT_W-1:0] PER_HI     = CNT_W'(PERIOD + PERIOD_TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CONF_W-1:0] CONF_MAX  = CONF_W'(CONFIRM);

    logic              w_rise;
    logic              w_fall;
    logic              w_timeout;
    dec_state_t        r_state;
    dec_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_hi_cnt;
    logic [CNT_W-1:0]  r_per_cnt;
    logic [CNT_W-1:0]  r_idle_cnt;
    logic [CONF_W-1:0] r_conf_cnt;
    logic [CONF_W-1:0] w_conf_nxt;
    pulse_cls_t        r_prev_cls;
    pulse_cls_t        w_cls;
    logic              r_per_bad;
    logic              w_per_ok;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic pulse_cls_t classify(input logic [CNT_W-1:0] w);
        if (w >= OPEN_LO && w <= OPEN_HI)
            return CLS_OPEN;
        else if (w >= CLOSE_LO && w <= CLOSE_HI)
            return CLS_CLOSE;
        else
            return CLS_NONE;
    endfunction

    pwm_edge_sync u_sync (
        .clk  (clock_50MHz),
        .rst  (reset),
        .din  (pwm_in),
        .rise (w_rise),
        .fall (w_fall)
    );

    // An edge in the same cycle always suppresses the timeout.
    assign w_timeout = !w_rise && !w_fall && (r_idle_cnt == TIMEOUT_M1);
    assign w_per_ok  = (r_per_cnt >= PER_LO) && (r_per_cnt <= PER_HI);
    assign w_cls     = classify(r_hi_cnt);

    always_comb begin
        w_conf_nxt = CONF_W'(1);
        if (w_cls == r_prev_cls)
            w_conf_nxt = (r_conf_cnt == CONF_MAX) ? r_conf_cnt : r_conf_cnt + 1'b1;
    end

    always_ff @(posedge clock_50MHz or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_rise) w_state_nxt = HIGH;
            HIGH:    if (w_fall) w_state_nxt = LOW;
            LOW:     if (w_rise) w_state_nxt = HIGH;
            default: w_state_nxt = IDLE;
        endcase
        if (w_timeout)
            w_state_nxt = IDLE;
    end

    // A rise seen in LOW always has a recorded previous rise; a rise in IDLE
    // (after reset or timeout) never does, so it skips the period check.
    always_ff @(posedge clock_50MHz or posedge reset) begin
        if (reset) begin
            r_hi_cnt    <= '0;
            r_per_cnt   <= '0;
            r_idle_cnt  <= '0;
            r_conf_cnt  <= '0;
            r_prev_cls  <= CLS_NONE;
            r_per_bad   <= 1'b0;
            pulse_width <= '0;
            width_valid <= 1'b0;
            gate_open   <= 1'b0;
            gate_closed <= 1'b0;
            pwm_error   <= 1'b0;
            signal_lost <= 1'b0;
        end else begin
            width_valid <= 1'b0;
            r_idle_cnt  <= (w_rise || w_fall) ? '0 : sat_inc(r_idle_cnt);
            r_per_cnt   <= sat_inc(r_per_cnt);
            r_hi_cnt    <= sat_inc(r_hi_cnt);

            if (w_rise) begin
                r_hi_cnt    <= CNT_W'(1);
                r_per_cnt   <= CNT_W'(1);
                signal_lost <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_rise)
                        r_per_bad <= 1'b0;
                end
                HIGH: begin
                    if (w_fall) begin
                        pulse_width <= r_hi_cnt;
                        width_valid <= 1'b1;
                        if (w_cls == CLS_NONE) begin
                            pwm_error  <= 1'b1;
                            r_conf_cnt <= '0;
                            r_prev_cls <= CLS_NONE;
                        end else begin
                            r_conf_cnt <= w_conf_nxt;
                            r_prev_cls <= w_cls;
                            if (w_conf_nxt == CONF_MAX) begin
                                gate_open   <= (w_cls == CLS_OPEN);
                                gate_closed <= (w_cls == CLS_CLOSE);
                            end
                            if (!r_per_bad)
                                pwm_error <= 1'b0;
                        end
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        r_per_bad <= !w_per_ok;
                        if (!w_per_ok)
                            pwm_error <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (w_timeout) begin
                signal_lost <= 1'b1;
                gate_open   <= 1'b0;
                gate_closed <= 1'b0;
                r_conf_cnt  <= '0;
            end
        end
    end

endmodule

`default_nettype wire
